// File: rtl/stepmania_pkg.sv
// Shared types and constants for the 4-lane receptor playfield.
// Lane state encoding, lane count and default HID arrow keycodes.
package stepmania_pkg;

    typedef enum logic [1:0] {
        LANE_IDLE  = 2'd0,
        LANE_PRESS = 2'd1,
        LANE_DECAY = 2'd2
    } lane_state_t;

    localparam int NUM_LANES = 4;

    localparam logic [7:0] DEF_KEY_LEFT  = 8'h50;
    localparam logic [7:0] DEF_KEY_DOWN  = 8'h51;
    localparam logic [7:0] DEF_KEY_UP    = 8'h52;
    localparam logic [7:0] DEF_KEY_RIGHT = 8'h4F;

    // 8'h00 means "no key reported" and must never select a lane.
    function automatic logic key_match(input logic [7:0] code, input logic [7:0] key);
        return (code != 8'h00) && (code == key);
    endfunction

endpackage

// File: rtl/receptor_ctrl_if.sv
// Keycode inputs and lane outputs of the receptor controller.
interface receptor_ctrl_if;
    logic [7:0] keycode0;
    logic [7:0] keycode1;
    logic [3:0] is_receptor;
    logic [3:0] press_pulse;
    logic       frame_tick;

    modport master (
        output keycode0,
        output keycode1,
        input  is_receptor,
        input  press_pulse,
        input  frame_tick
    );

    modport slave (
        input  keycode0,
        input  keycode1,
        output is_receptor,
        output press_pulse,
        output frame_tick
    );
endinterface

// File: rtl/receptor_lane.sv
// Single-lane press/decay sequencer: lit while pressed and for FLASH_FRAMES
// frame ticks after release; also produces the new-press pulse.
//
//  state      | meaning
//  LANE_IDLE  | lane dark, waiting for its key
//  LANE_PRESS | key held, lane lit
//  LANE_DECAY | key released, lane lit until cnt frame ticks have elapsed
module receptor_lane
    import stepmania_pkg::*;
#(
    parameter int FLASH_FRAMES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic key,
    input  logic frame_tick,
    output logic lit,
    output logic press_pulse
);

    if (FLASH_FRAMES < 1 || FLASH_FRAMES > 15) begin : g_bad_flash
        $error("receptor_lane: FLASH_FRAMES must be in 1..15");
    end

    lane_state_t state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        key_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= LANE_IDLE;
            cnt   <= 4'd0;
            key_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            key_q <= key;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            LANE_IDLE: begin
                if (key) state_n = LANE_PRESS;
            end
            LANE_PRESS: begin
                if (!key) begin
                    state_n = LANE_DECAY;
                    cnt_n   = 4'(FLASH_FRAMES);
                end
            end
            LANE_DECAY: begin
                if (key) begin
                    state_n = LANE_PRESS;
                    cnt_n   = 4'd0;
                end else if (frame_tick) begin
                    if (cnt == 4'd1) begin
                        state_n = LANE_IDLE;
                        cnt_n   = 4'd0;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
            end
            default: begin
                state_n = LANE_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    assign lit = (state != LANE_IDLE);

    // Held reset keeps the pulse quiet even while a key is already down.
    assign press_pulse = key & ~key_q & ~Reset;

endmodule

// File: rtl/receptor_ctrl.sv
// Receptor sequencer top: keycode decode, frame_clk synchroniser and edge
// detect, four lane sequencers and the frame-stable is_receptor register.
module receptor_ctrl
    import stepmania_pkg::*;
#(
    parameter logic [7:0] KEY_LEFT     = DEF_KEY_LEFT,
    parameter logic [7:0] KEY_DOWN     = DEF_KEY_DOWN,
    parameter logic [7:0] KEY_UP       = DEF_KEY_UP,
    parameter logic [7:0] KEY_RIGHT    = DEF_KEY_RIGHT,
    parameter int         FLASH_FRAMES = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_clk,
    receptor_ctrl_if.slave  bus
);

    localparam logic [8*NUM_LANES-1:0] LANE_KEYS = {KEY_RIGHT, KEY_UP, KEY_DOWN, KEY_LEFT};

    logic                 sync_a, sync_b, sync_prev;
    logic                 tick;
    logic [NUM_LANES-1:0] key;
    logic [NUM_LANES-1:0] lit;
    logic [NUM_LANES-1:0] pulse;
    logic [NUM_LANES-1:0] receptor_q;

    // Two synchroniser flops plus a registered edge detect: tick lands on the third Clk.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            sync_prev <= 1'b0;
            tick      <= 1'b0;
        end else begin
            sync_a    <= frame_clk;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
            tick      <= sync_b & ~sync_prev;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign key[i] = key_match(bus.keycode0, LANE_KEYS[8*i +: 8]) |
                        key_match(bus.keycode1, LANE_KEYS[8*i +: 8]);

        receptor_lane #(
            .FLASH_FRAMES (FLASH_FRAMES)
        ) u_lane (
            .Clk         (Clk),
            .Reset       (Reset),
            .key         (key[i]),
            .frame_tick  (tick),
            .lit         (lit[i]),
            .press_pulse (pulse[i])
        );
    end

    // Captures the pre-transition lit vector so a lane never changes mid-frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            receptor_q <= '0;
        end else if (tick) begin
            receptor_q <= lit;
        end
    end

    assign bus.is_receptor = receptor_q;
    assign bus.press_pulse = pulse;
    assign bus.frame_tick  = tick;

endmodule

// File: tb/tb_receptor_ctrl.sv
// Directed bench for receptor_ctrl: reset, press, decay, tap, multi-lane,
// re-press and mid-decay reset, with hand-computed expectations.
module tb_receptor_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic frame_clk = 1'b0;

    receptor_ctrl_if bus ();

    receptor_ctrl #(
        .FLASH_FRAMES (4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic t2, t3, t4;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One frame: frame_clk high, record frame_tick after 2/3/4 edges, then low.
    task automatic frame();
        frame_clk = 1'b1;
        step(); step();
        t2 = bus.frame_tick;
        step();
        t3 = bus.frame_tick;
        step();
        t4 = bus.frame_tick;
        frame_clk = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.keycode0 = 8'h50;
        bus.keycode1 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            frame_clk = ~frame_clk;
            step();
        end
        n_tests++;
        if (bus.is_receptor !== 4'b0000 || bus.press_pulse !== 4'b0000 || bus.frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: rec=%b pulse=%b tick=%b, want 0000 0000 0", bus.is_receptor, bus.press_pulse, bus.frame_tick);
        end
        frame_clk = 1'b0;
        bus.keycode0 = 8'h00;
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (bus.is_receptor !== 4'b0000 || bus.press_pulse !== 4'b0000 || bus.frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release: rec=%b pulse=%b tick=%b, want 0000 0000 0", bus.is_receptor, bus.press_pulse, bus.frame_tick);
            end
        end
    endtask

    task automatic test_press();
        bus.keycode0 = 8'h50;
        #1;
        n_tests++;
        if (bus.press_pulse !== 4'b0001) begin
            n_fail++;
            $display("FAIL press_pulse: got %b want 0001", bus.press_pulse);
        end
        step();
        n_tests++;
        if (bus.press_pulse !== 4'b0000 || bus.is_receptor !== 4'b0000) begin
            n_fail++;
            $display("FAIL press_pulse_end: pulse=%b rec=%b want 0000 0000", bus.press_pulse, bus.is_receptor);
        end
        for (int f = 0; f < 3; f++) begin
            frame();
            n_tests++;
            if ({t2, t3, t4} !== 3'b010) begin
                n_fail++;
                $display("FAIL tick_timing: t2/t3/t4=%b%b%b want 010", t2, t3, t4);
            end
            n_tests++;
            if (bus.is_receptor !== 4'b0001) begin
                n_fail++;
                $display("FAIL press_lit frame %0d: got %b want 0001", f, bus.is_receptor);
            end
        end
    endtask

    task automatic test_decay();
        bus.keycode0 = 8'h00;
        step();
        for (int f = 1; f <= 5; f++) begin
            frame();
            n_tests++;
            if (bus.is_receptor !== ((f <= 4) ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL decay frame %0d: got %b want %b", f, bus.is_receptor, (f <= 4) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_tap();
        bus.keycode0 = 8'h4F;
        #1;
        n_tests++;
        if (bus.press_pulse !== 4'b1000) begin
            n_fail++;
            $display("FAIL tap_pulse: got %b want 1000", bus.press_pulse);
        end
        step(); step();
        bus.keycode0 = 8'h00;
        step();
        for (int f = 1; f <= 5; f++) begin
            frame();
            n_tests++;
            if (bus.is_receptor !== ((f <= 4) ? 4'b1000 : 4'b0000)) begin
                n_fail++;
                $display("FAIL tap frame %0d: got %b want %b", f, bus.is_receptor, (f <= 4) ? 4'b1000 : 4'b0000);
            end
        end
    endtask

    task automatic test_two_lanes();
        bus.keycode0 = 8'h51;
        bus.keycode1 = 8'h52;
        #1;
        n_tests++;
        if (bus.press_pulse !== 4'b0110) begin
            n_fail++;
            $display("FAIL dual_pulse: got %b want 0110", bus.press_pulse);
        end
        step();
        n_tests++;
        if (bus.press_pulse !== 4'b0000) begin
            n_fail++;
            $display("FAIL dual_pulse_end: got %b want 0000", bus.press_pulse);
        end
        frame();
        n_tests++;
        if (bus.is_receptor !== 4'b0110) begin
            n_fail++;
            $display("FAIL dual_lit: got %b want 0110", bus.is_receptor);
        end
        bus.keycode0 = 8'h00;
        bus.keycode1 = 8'h00;
        step();
        bus.keycode0 = 8'h51;
        bus.keycode1 = 8'h51;
        #1;
        n_tests++;
        if (bus.press_pulse !== 4'b0010) begin
            n_fail++;
            $display("FAIL same_key_pulse: got %b want 0010", bus.press_pulse);
        end
        step();
        bus.keycode0 = 8'h00;
        bus.keycode1 = 8'h00;
        step();
        for (int f = 0; f < 5; f++) frame();
        n_tests++;
        if (bus.is_receptor !== 4'b0000) begin
            n_fail++;
            $display("FAIL dual_decayed: got %b want 0000", bus.is_receptor);
        end
    endtask

    task automatic test_repress_reset();
        bus.keycode0 = 8'h52;
        step();
        bus.keycode0 = 8'h00;
        step();
        frame();
        frame();
        n_tests++;
        if (bus.is_receptor !== 4'b0100) begin
            n_fail++;
            $display("FAIL repress_pre: got %b want 0100", bus.is_receptor);
        end
        bus.keycode0 = 8'h52;
        #1;
        n_tests++;
        if (bus.press_pulse !== 4'b0100) begin
            n_fail++;
            $display("FAIL repress_pulse: got %b want 0100", bus.press_pulse);
        end
        step();
        for (int f = 1; f <= 3; f++) begin
            frame();
            n_tests++;
            if (bus.is_receptor !== 4'b0100) begin
                n_fail++;
                $display("FAIL repress_hold frame %0d: got %b want 0100", f, bus.is_receptor);
            end
        end
        bus.keycode0 = 8'h00;
        step();
        frame();
        #2;
        Reset = 1'b1;
        frame_clk = 1'b1;
        #1;
        n_tests++;
        if (bus.is_receptor !== 4'b0000 || bus.press_pulse !== 4'b0000 || bus.frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: rec=%b pulse=%b tick=%b want 0000 0000 0", bus.is_receptor, bus.press_pulse, bus.frame_tick);
        end
        step();
        step();
        Reset = 1'b0;
        step(); step();
        n_tests++;
        if (bus.frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_tick_early: got %b want 0", bus.frame_tick);
        end
        step();
        n_tests++;
        if (bus.frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_tick: got %b want 1", bus.frame_tick);
        end
        step();
        n_tests++;
        if (bus.is_receptor !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b want 0000", bus.is_receptor);
        end
        frame_clk = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        bus.keycode0 = 8'h00;
        bus.keycode1 = 8'h00;
        test_reset();
        test_press();
        test_decay();
        test_tap();
        test_two_lanes();
        test_repress_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
